conv_frame_streamer: RTL

Serializes one completed convolution output frame (DIM×DIM pixels, presented as a wide parallel bus) into a pixel-per-cycle stream with a valid/ready handshake. It sits on the read side of the convolution stage and feeds downstream pooling, compare or output logic that cannot consume a full frame in parallel. It captures the frame into an internal buffer, so the convolution stage may change its outputs as soon as the capture handshake completes.

---
 rtl/conv_frame_streamer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/conv_frame_streamer.sv
// conv_frame_streamer
//   Captures one DIM x DIM convolution output frame from a wide parallel bus
//   into an internal buffer, then streams it out one pixel per cycle over a
//   valid/ready handshake. Pixel k = row*DIM + col, streamed in increasing k.
//
// Optional feature macro: CONV_STREAM_RELU_EN
//   defined   -> negative pixels are clamped to zero on the output path
//                (the buffer keeps raw values, no added latency)
//   undefined -> pixels stream unchanged
//
// Parameters:
//   WIDTH  pixel width in bits (two's complement)
//   DIM    frame side length; frame holds DIM*DIM pixels
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   frame_in     parallel frame, DIM*DIM pixels of WIDTH bits
//   frame_valid  frame_in holds a complete frame
//   frame_ready  block can capture a frame (IDLE)
//   out_data     current pixel
//   out_valid    out_data is valid (STREAM)
//   out_ready    downstream accepts out_data
//   out_eol      current pixel is last of its row
//   out_last     current pixel is last of the frame
module conv_frame_streamer #(
  parameter int WIDTH = 16,
  parameter int DIM   = 30
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIM*DIM-1:0][WIDTH-1:0]    frame_in,
  input  logic                             frame_valid,
  output logic                             frame_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_eol,
  output logic                             out_last
);

  localparam int NPIX = DIM * DIM;
  localparam int KW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [KW-1:0]                  r_k;
  logic [KW-1:0]                  w_k_nxt;
  // Column counter runs alongside k so end-of-row needs no modulo.
  logic [CW-1:0]                  r_col;
  logic [CW-1:0]                  w_col_nxt;
  logic [NPIX-1:0][WIDTH-1:0]     r_buf;
  logic                           w_capture;
  logic                           w_k_end;
  logic                           w_col_end;
  logic [WIDTH-1:0]               w_raw;
  logic [WIDTH-1:0]               w_pix;

  assign w_k_end   = (r_k == KW'(NPIX - 1));
  assign w_col_end = (r_col == CW'(DIM - 1));
  assign w_raw     = r_buf[r_k];

`ifdef CONV_STREAM_RELU_EN
  assign w_pix = w_raw[WIDTH-1] ? '0 : w_raw;
`else
  assign w_pix = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf <= frame_in;
    end
  end

  // Outputs decode only registered state; out_ready and frame_valid affect
  // next-state alone, so there is no input-to-output combinational path.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_col_nxt   = r_col;
    w_capture   = 1'b0;
    frame_ready = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_eol     = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_STREAM;
          w_k_nxt     = '0;
          w_col_nxt   = '0;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = w_pix;
        out_eol   = w_col_end;
        out_last  = w_k_end;
        if (out_ready) begin
          if (w_k_end) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_k_nxt   = r_k + 1'b1;
            w_col_nxt = w_col_end ? '0 : r_col + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
